// File: rtl/mul_cdb_buffer_pkg.sv
// Shared types and default sizing for the multiplier-to-CDB result buffer.
// The packet is what the buffer presents to the CDB for one completed multiply.
package mul_cdb_buffer_pkg;

  localparam int XLEN          = 32;
  localparam int PRF_LEN       = 6;
  localparam int ROB_LEN       = 5;
  localparam int MUL_LAT       = 8;
  localparam int MUL_BUF_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    PC;
  } MUL_CDB_PACKET;

endpackage

// File: rtl/mul_buf_fifo.sv
// Generic DEPTH-entry register FIFO of MUL_CDB_PACKET with push, pop and flush.
// Flush wins over push/pop; a push into a full FIFO is dropped.
module mul_buf_fifo
  import mul_cdb_buffer_pkg::*;
#(
  parameter int DEPTH = MUL_BUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  MUL_CDB_PACKET       wdata,
  output MUL_CDB_PACKET       rdata,
  output logic [CNT_W-1:0]    count,
  output logic                empty,
  output logic                full
);

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;
  MUL_CDB_PACKET    entry_q [DEPTH];

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      MUL_CDB_PACKET entry_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else if (do_push && (tail_reg == PTR_W'(gi))) begin
          entry_reg <= wdata;
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= tail_reg;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign rdata = entry_q[head_reg];
  assign count = count_reg;

endmodule

// File: rtl/mul_cdb_buffer.sv
// Result buffer between the non-stallable multiplier and the CDB, with issue credits
// and post-squash result dropping. Define MUL_CDB_BUFFER_BYPASS_EN for 0-cycle bypass when empty.
module mul_cdb_buffer
  import mul_cdb_buffer_pkg::MUL_CDB_PACKET, mul_cdb_buffer_pkg::XLEN,
         mul_cdb_buffer_pkg::PRF_LEN, mul_cdb_buffer_pkg::ROB_LEN,
         mul_cdb_buffer_pkg::MUL_BUF_DEPTH;
#(
  parameter int DEPTH   = MUL_BUF_DEPTH,
  parameter int MUL_LAT = mul_cdb_buffer_pkg::MUL_LAT,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int FLY_W  = $clog2(MUL_LAT + DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mul_issue,
  input  logic                mul_valid,
  input  logic [XLEN-1:0]     mul_value,
  input  logic [PRF_LEN-1:0]  mul_prf_idx,
  input  logic [ROB_LEN-1:0]  mul_rob_idx,
  input  logic [XLEN-1:0]     mul_PC,
  input  logic                squash,
  input  logic                cdb_grant,
  output logic                issue_ok,
  output logic                buf_valid,
  output MUL_CDB_PACKET       buf_packet,
  output logic [CNT_W-1:0]    buf_count
);

  localparam int SUM_W = FLY_W + 1;

  logic [FLY_W-1:0] inflight_reg;
  logic [FLY_W-1:0] inflight_next;
  logic [FLY_W-1:0] drop_cnt_reg;
  logic [FLY_W-1:0] drop_cnt_next;
  logic             push_ok;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  MUL_CDB_PACKET    in_pkt;
  MUL_CDB_PACKET    head_pkt;

  assign in_pkt = '{value: mul_value, prf_idx: mul_prf_idx, rob_idx: mul_rob_idx, PC: mul_PC};

  // The multiplier is never flushed, so inflight tracks every op regardless of squash.
  assign inflight_next = inflight_reg + FLY_W'(mul_issue) - FLY_W'(mul_valid);

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (squash) begin
      drop_cnt_next = inflight_next;
    end else if (mul_valid && (drop_cnt_reg != '0)) begin
      drop_cnt_next = drop_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Registered values only: a slot freed this cycle is offered one cycle later.
  assign issue_ok = (SUM_W'(fifo_count) + SUM_W'(inflight_reg)) < SUM_W'(DEPTH);

  assign push_ok  = mul_valid && (drop_cnt_reg == '0) && !squash;
  assign fifo_pop = !fifo_empty && cdb_grant && !squash;

`ifdef MUL_CDB_BUFFER_BYPASS_EN
  logic bypass;

  // An incoming result granted straight through never occupies a FIFO slot.
  assign bypass     = fifo_empty && push_ok;
  assign fifo_push  = push_ok && !(bypass && cdb_grant);
  assign buf_valid  = !fifo_empty || bypass;
  assign buf_packet = bypass ? in_pkt : head_pkt;
`else
  assign fifo_push  = push_ok;
  assign buf_valid  = !fifo_empty;
  assign buf_packet = head_pkt;
`endif

  mul_buf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (squash),
    .wdata (in_pkt),
    .rdata (head_pkt),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign buf_count = fifo_count;

  a_issue_credit: assert property (@(posedge clock) disable iff (!reset)
    mul_issue |-> issue_ok);

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_mul_cdb_buffer.sv
// Directed bench for mul_cdb_buffer: acts as the multiplier and CDB arbiter, keeps
// a queue-level model (ops in flight with kill marks, buffered results) and checks every cycle.
module tb_mul_cdb_buffer;
  import mul_cdb_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 8;

  typedef struct {
    int            due;
    MUL_CDB_PACKET pkt;
    bit            killed;
  } op_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              mul_issue = 1'b0;
  logic              mul_valid = 1'b0;
  logic [XLEN-1:0]   mul_value = '0;
  logic [PRF_LEN-1:0] mul_prf_idx = '0;
  logic [ROB_LEN-1:0] mul_rob_idx = '0;
  logic [XLEN-1:0]   mul_PC = '0;
  logic              squash = 1'b0;
  logic              cdb_grant = 1'b0;
  logic              issue_ok;
  logic              buf_valid;
  MUL_CDB_PACKET     buf_packet;
  logic [2:0]        buf_count;

  mul_cdb_buffer #(.DEPTH(DEPTH), .MUL_LAT(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .mul_issue   (mul_issue),
    .mul_valid   (mul_valid),
    .mul_value   (mul_value),
    .mul_prf_idx (mul_prf_idx),
    .mul_rob_idx (mul_rob_idx),
    .mul_PC      (mul_PC),
    .squash      (squash),
    .cdb_grant   (cdb_grant),
    .issue_ok    (issue_ok),
    .buf_valid   (buf_valid),
    .buf_packet  (buf_packet),
    .buf_count   (buf_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int issued = 0;

  op_t           pipe[$];
  MUL_CDB_PACKET q[$];
  logic [4:0]    delivered[$];

  bit            check_en = 0;
  bit            exp_issue_ok;
  bit            exp_valid;
  int            exp_count;
  MUL_CDB_PACKET exp_pkt;

  logic [31:0]   nv = 0;
  logic [4:0]    nr = 0;

  bit            smp_valid;
  bit            smp_ok;
  int            smp_count;
  MUL_CDB_PACKET smp_pkt;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle the outputs are meaningful, the DUT must match the model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("issue_ok", 96'(issue_ok), 96'(exp_issue_ok));
      chk("buf_valid", 96'(buf_valid), 96'(exp_valid));
      chk("buf_count", 96'(buf_count), 96'(exp_count));
      if (exp_valid) chk("buf_packet", 96'(buf_packet), 96'(exp_pkt));
    end
  end

  // One clock cycle: drive inputs, publish expectations, sample, then advance the model.
  task automatic step(input bit want_issue, input bit grant, input bit sq);
    bit            mv, kill, pushable, iss, popped, consumed;
    MUL_CDB_PACKET inc;
    op_t           op;
    mv = 0; kill = 0; inc = '0;
    if (pipe.size() != 0) begin
      if (pipe[0].due == cyc) begin
        mv = 1; inc = pipe[0].pkt; kill = pipe[0].killed;
      end
    end
    pushable     = mv && !kill && !sq;
    exp_issue_ok = (q.size() + pipe.size()) < DEPTH;
    iss          = want_issue && exp_issue_ok;
    exp_count    = q.size();
    exp_valid    = (q.size() != 0);
    exp_pkt      = exp_valid ? q[0] : '0;
`ifdef MUL_CDB_BUFFER_BYPASS_EN
    if (q.size() == 0 && pushable) begin
      exp_valid = 1; exp_pkt = inc;
    end
`endif
    mul_issue   = iss;
    mul_valid   = mv;
    mul_value   = inc.value;
    mul_prf_idx = inc.prf_idx;
    mul_rob_idx = inc.rob_idx;
    mul_PC      = inc.PC;
    cdb_grant   = grant;
    squash      = sq;
    check_en    = 1;
    @(negedge clock);
    smp_valid = buf_valid; smp_ok = issue_ok; smp_count = int'(buf_count); smp_pkt = buf_packet;
    if (smp_valid && grant && !sq) begin
      delivered.push_back(smp_pkt.rob_idx);
      $display("cdb cycle=%0d rob=%0d prf=%0d value=%h pc=%h", cyc, smp_pkt.rob_idx,
               smp_pkt.prf_idx, smp_pkt.value, smp_pkt.PC);
    end
    @(posedge clock);
    #1;
    if (mv) void'(pipe.pop_front());
    popped   = (q.size() != 0) && grant && !sq;
    consumed = 0;
`ifdef MUL_CDB_BUFFER_BYPASS_EN
    consumed = (q.size() == 0) && pushable && grant;
`endif
    if (popped) void'(q.pop_front());
    if (pushable && !consumed) q.push_back(inc);
    if (iss) begin
      op.due = cyc + LAT;
      op.pkt.value   = nv;
      op.pkt.rob_idx = nr;
      op.pkt.prf_idx = 6'(nr) + 6'd1;
      op.pkt.PC      = 32'h0000_1000 + 32'(nr) * 4;
      op.killed      = 0;
      pipe.push_back(op);
      nv = nv + 3; nr = nr + 1; issued++;
    end
    if (sq) begin
      q.delete();
      foreach (pipe[i]) pipe[i].killed = 1;
    end
    cyc++;
    mul_issue = 0; mul_valid = 0; cdb_grant = 0; squash = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clock);
    #3 reset = 1;
    #1;
    chk("reset_valid", 96'(buf_valid), 96'd0);
    chk("reset_count", 96'(buf_count), 96'd0);
    chk("reset_issue_ok", 96'(issue_ok), 96'd1);
    chk("reset_packet", 96'(buf_packet), 96'd0);

    // Single op: issue at c, result at c+8, visible at c+9 through the FIFO.
    nv = 32'h0000_0006; nr = 5'd3;
    step(1, 0, 0);
    idle(7);
    step(0, 0, 0);
`ifdef MUL_CDB_BUFFER_BYPASS_EN
    chk("single_c8_valid", 96'(smp_valid), 96'd1);
`else
    chk("single_c8_valid", 96'(smp_valid), 96'd0);
`endif
    step(0, 1, 0);
    chk("single_c9_valid", 96'(smp_valid), 96'd1);
    chk("single_c9_value", 96'(smp_pkt.value), 96'h6);
    chk("single_c9_rob", 96'(smp_pkt.rob_idx), 96'd3);
    step(0, 0, 0);
    chk("single_c10_valid", 96'(smp_valid), 96'd0);

    // Credit backpressure with no grants.
    nv = 32'd100; nr = 5'd8; issued = 0;
    for (int i = 0; i < 14; i++) step(1, 0, 0);
    chk("credit_issued", 96'(issued), 96'd4);
    chk("credit_count_full", 96'(buf_count), 96'd4);
    chk("credit_issue_ok_low", 96'(issue_ok), 96'd0);
    step(0, 1, 0);
    chk("credit_ok_in_grant_cycle", 96'(smp_ok), 96'd0);
    chk("credit_ok_after_grant", 96'(issue_ok), 96'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 0);

    // Simultaneous push and pop at count 2.
    nv = 32'd200; nr = 5'd0;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    idle(7);
    step(0, 1, 0);
    chk("pushpop_count_before", 96'(smp_count), 96'd2);
    chk("pushpop_count_after", 96'(buf_count), 96'd2);
    for (int i = 0; i < 4; i++) step(0, 1, 0);

    // Ten ops through the 4-entry FIFO with grants every other cycle.
    delivered.delete(); issued = 0; nr = 5'd10; nv = 32'h0000_0a00;
    for (int i = 0; i < 60; i++) step(issued < 10, i[0], 0);
    chk("wrap_delivered", 96'(delivered.size()), 96'd10);
    for (int k = 0; k < delivered.size(); k++) chk("wrap_order", 96'(delivered[k]), 96'(10 + k));

    // Squash with 2 buffered and 2 in flight, then a younger op.
    nv = 32'h40; nr = 5'd24;
    step(1, 0, 0); step(1, 0, 0);
    idle(8);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 1);
    chk("squash_count", 96'(buf_count), 96'd0);
    nv = 32'h55; nr = 5'd20;
    step(1, 0, 0);
    idle(4);
    step(0, 0, 0);
    chk("squash_drop1_count", 96'(smp_count), 96'd0);
    step(0, 0, 0);
    chk("squash_drop2_count", 96'(smp_count), 96'd0);
    step(0, 0, 0);
    chk("squash_drop_after", 96'(buf_count), 96'd0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("squash_young_valid", 96'(smp_valid), 96'd1);
    chk("squash_young_value", 96'(smp_pkt.value), 96'h55);
    chk("squash_young_rob", 96'(smp_pkt.rob_idx), 96'd20);

    // Arrival into an empty FIFO with grant in the same cycle.
    nv = 32'h77; nr = 5'd7;
    step(1, 0, 0);
    idle(7);
    step(0, 1, 0);
`ifdef MUL_CDB_BUFFER_BYPASS_EN
    chk("bypass_valid", 96'(smp_valid), 96'd1);
    chk("bypass_value", 96'(smp_pkt.value), 96'h77);
    chk("bypass_count", 96'(buf_count), 96'd0);
`else
    chk("nobypass_valid", 96'(smp_valid), 96'd0);
    chk("nobypass_count", 96'(buf_count), 96'd1);
    step(0, 1, 0);
    chk("nobypass_late_valid", 96'(smp_valid), 96'd1);
    chk("nobypass_late_value", 96'(smp_pkt.value), 96'h77);
`endif

    // Reset in the middle of traffic.
    nv = 32'h90; nr = 5'd1;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    idle(7);
    check_en = 0;
    #2 reset = 0;
    #1;
    chk("midreset_valid", 96'(buf_valid), 96'd0);
    chk("midreset_count", 96'(buf_count), 96'd0);
    chk("midreset_issue_ok", 96'(issue_ok), 96'd1);
    q.delete(); pipe.delete();
    repeat (2) @(posedge clock);
    #3 reset = 1;
    idle(12);
    chk("postreset_count", 96'(buf_count), 96'd0);
    chk("postreset_valid", 96'(buf_valid), 96'd0);

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
